// File: rtl/acc_dp_pkg.sv
// Shared encodings for the accumulator datapath.
//   alu_op_e   : ALU / multiplier operation select
//   ac_src_e   : accumulator load source
//   opnd_sel_e : ALU operand B source
//   adr_sel_e  : memory address source
//   out_sel_e  : memory write-data source
//   imm_mode_e : immediate extraction from IR
//   pc_src_e   : program counter load source
//   mul_state_e: sequential multiplier state
//   FLAG_*     : bit positions inside the {Z,N,C,V} status nibble
package acc_dp_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_NOT = 3'd3,
      ALU_SHL = 3'd4,
      ALU_SHR = 3'd5,
      ALU_ASR = 3'd6,
      ALU_MUL = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      ACS_IMM  = 2'd0,
      ACS_DIN  = 2'd1,
      ACS_ALU  = 2'd2,
      ACS_RSVD = 2'd3
   } ac_src_e;

   typedef enum logic [1:0] {
      OPB_IMM  = 2'd0,
      OPB_DIN  = 2'd1,
      OPB_ONE  = 2'd2,
      OPB_RSVD = 2'd3
   } opnd_sel_e;

   typedef enum logic [1:0] {
      ADR_IN     = 2'd0,
      ADR_IMM    = 2'd1,
      ADR_PC     = 2'd2,
      ADR_PC_ALT = 2'd3
   } adr_sel_e;

   typedef enum logic [1:0] {
      OUT_IN     = 2'd0,
      OUT_PC_INC = 2'd1,
      OUT_AC     = 2'd2,
      OUT_RSVD   = 2'd3
   } out_sel_e;

   typedef enum logic [1:0] {
      IMM_ZEXT12 = 2'd0,
      IMM_SEXT12 = 2'd1,
      IMM_SEXT4  = 2'd2,
      IMM_PAGE   = 2'd3
   } imm_mode_e;

   typedef enum logic [1:0] {
      PCS_INC  = 2'd0,
      PCS_DIN  = 2'd1,
      PCS_IMM  = 2'd2,
      PCS_RSVD = 2'd3
   } pc_src_e;

   typedef enum logic {
      MUL_IDLE = 1'b0,
      MUL_RUN  = 1'b1
   } mul_state_e;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/acc_datapath_mc_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
//   clk, rst : clock, synchronous active-high reset
//   start    : capture a/b and begin (ignored while busy)
//   a, b     : multiplicand / multiplier
//   busy     : high for the DW cycles following the start edge
//   done     : high during the last busy cycle; product is valid then
//   product  : full 2*DW-bit result, meaningful only while done=1
//
// state    | meaning
// ---------+--------------------------------------------------
// MUL_IDLE | waiting for start
// MUL_RUN  | adding shifted multiplicand, cnt_q bits remaining
module seq_multiplier
   import acc_dp_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic            busy,
   output logic            done,
   output logic [2*DW-1:0] product
);

   localparam int CW = $clog2(DW + 1);

   mul_state_e      state_q, state_d;
   logic [2*DW-1:0] mcand_q, mcand_d;
   logic [2*DW-1:0] acc_q, acc_d;
   logic [DW-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MUL_IDLE;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      done     = 1'b0;
      case (state_q)
         MUL_IDLE: begin
            if (start) begin
               mcand_d  = {{DW{1'b0}}, a};
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = CW'(DW);
               state_d  = MUL_RUN;
            end
         end
         MUL_RUN: begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            // Terminal count: the last partial product lands this cycle.
            if (cnt_q == CW'(1)) begin
               done    = 1'b1;
               state_d = MUL_IDLE;
            end
         end
         default: state_d = MUL_IDLE;
      endcase
   end

   assign busy    = (state_q == MUL_RUN);
   // In the done cycle acc_d already holds the final sum, so the result can
   // be committed at the same edge that ends the operation.
   assign product = acc_d;

endmodule

// File: rtl/acc_datapath_mc.sv
// Accumulator datapath with a bank of NAC accumulators, combinational ALU,
// iterative multiplier, IR/PC/IN/OF/SR registers and memory-side muxing.
//   clk, rst         : clock, synchronous active-high reset
//   data_in          : memory read data
//   data_out/data_oe : registered write data and its enable
//   wr_en, out_sel   : capture write data next edge / its source
//   addr, adr_sel    : memory address and its source
//   ac_sel/ac_src    : accumulator index / load source
//   ld_ac, zero_ac   : load / clear the selected accumulator
//   alu_op, opnd_sel : ALU operation / operand B source
//   start/busy/done  : multiplier handshake
//   imm_mode         : immediate extraction from IR
//   ld_ir, ld_of, of_src, ld_pc, pc_src, pc_inc2, ld_in, in_src : register loads
//   ld_sr, sr_src    : per-flag status load mask / source
//   ir_out, sr_out, skip : controller-facing status
module acc_datapath_mc
   import acc_dp_pkg::*;
#(
   parameter int DW  = 16,
   parameter int NAC = 4,
   parameter int OFW = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DW-1:0]           data_in,
   output logic [DW-1:0]           data_out,
   output logic                    data_oe,
   input  logic                    wr_en,
   input  logic [1:0]              out_sel,
   input  logic [1:0]              adr_sel,
   output logic [DW-1:0]           addr,
   input  logic [$clog2(NAC)-1:0]  ac_sel,
   input  logic [1:0]              ac_src,
   input  logic                    ld_ac,
   input  logic                    zero_ac,
   input  logic [2:0]              alu_op,
   input  logic [1:0]              opnd_sel,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   input  logic [1:0]              imm_mode,
   input  logic                    ld_ir,
   input  logic                    ld_of,
   input  logic                    of_src,
   input  logic                    ld_pc,
   input  logic [1:0]              pc_src,
   input  logic                    pc_inc2,
   input  logic                    ld_in,
   input  logic                    in_src,
   input  logic [3:0]              ld_sr,
   input  logic                    sr_src,
   output logic [DW-1:0]           ir_out,
   output logic [3:0]              sr_out,
   output logic                    skip
);

   localparam int AW = $clog2(NAC);

   logic [DW-1:0]   ac_q [NAC];
   logic [DW-1:0]   ac_d [NAC];
   logic [DW-1:0]   ir_q, ir_d, pc_q, pc_d, in_q, in_d, dout_q, dout_d;
   logic [OFW-1:0]  of_q, of_d;
   logic [3:0]      sr_q, sr_d;
   logic            oe_q;
   logic [AW-1:0]   mul_ac_q, mul_ac_d;

   alu_op_e         op;
   logic [DW-1:0]   imm, opnd_a, opnd_b, alu_res, pc_inc;
   logic [DW:0]     ext;
   logic            alu_c, alu_v;
   logic [3:0]      flags;
   logic            mul_start, mul_busy, mul_done, ac_lock;
   logic [2*DW-1:0] mul_prod;

   assign op     = alu_op_e'(alu_op);
   assign opnd_a = ac_q[ac_sel];
   assign pc_inc = pc_q + (pc_inc2 ? DW'(2) : DW'(1));

   always_comb begin
      case (imm_mode_e'(imm_mode))
         IMM_ZEXT12: imm = DW'(ir_q[11:0]);
         IMM_SEXT12: imm = {{(DW-12){ir_q[11]}}, ir_q[11:0]};
         IMM_SEXT4:  imm = {{(DW-4){ir_q[3]}}, ir_q[3:0]};
         default:    imm = DW'({of_q, ir_q[11:0]});
      endcase
   end

   always_comb begin
      case (opnd_sel_e'(opnd_sel))
         OPB_IMM: opnd_b = imm;
         OPB_DIN: opnd_b = data_in;
         default: opnd_b = DW'(1);
      endcase
   end

   always_comb begin
      alu_res = opnd_a;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      ext     = '0;
      case (op)
         ALU_ADD: begin
            ext     = {1'b0, opnd_a} + {1'b0, opnd_b};
            alu_res = ext[DW-1:0];
            alu_c   = ext[DW];
            alu_v   = (opnd_a[DW-1] == opnd_b[DW-1]) && (alu_res[DW-1] != opnd_a[DW-1]);
         end
         ALU_SUB: begin
            // Bit DW of the widened difference is the borrow.
            ext     = {1'b0, opnd_a} - {1'b0, opnd_b};
            alu_res = ext[DW-1:0];
            alu_c   = ext[DW];
            alu_v   = (opnd_a[DW-1] != opnd_b[DW-1]) && (alu_res[DW-1] != opnd_a[DW-1]);
         end
         ALU_AND: alu_res = opnd_a & opnd_b;
         ALU_NOT: alu_res = ~opnd_a;
         ALU_SHL: begin
            alu_res = {opnd_a[DW-2:0], 1'b0};
            alu_c   = opnd_a[DW-1];
         end
         ALU_SHR: begin
            alu_res = {1'b0, opnd_a[DW-1:1]};
            alu_c   = opnd_a[0];
         end
         ALU_ASR: begin
            alu_res = {opnd_a[DW-1], opnd_a[DW-1:1]};
            alu_c   = opnd_a[0];
         end
         default: ;
      endcase

      flags[FLAG_Z] = ~|alu_res;
      flags[FLAG_N] = alu_res[DW-1];
      flags[FLAG_C] = alu_c;
      flags[FLAG_V] = alu_v;
      // The multiplier result owns the flag outputs for its done cycle.
      if (mul_done) begin
         flags[FLAG_Z] = ~|mul_prod[DW-1:0];
         flags[FLAG_N] = mul_prod[DW-1];
         flags[FLAG_C] = |mul_prod[2*DW-1:DW];
         flags[FLAG_V] = |mul_prod[2*DW-1:DW];
      end
   end

   assign mul_start = start && (op == ALU_MUL) && !mul_busy;

   seq_multiplier #(.DW(DW)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (opnd_a),
      .b       (opnd_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_prod)
   );

   // The accumulator owed a multiplier result is frozen to the controller.
   assign ac_lock  = mul_busy && (ac_sel == mul_ac_q);
   assign mul_ac_d = mul_start ? ac_sel : mul_ac_q;

   always_comb begin
      for (int i = 0; i < NAC; i++) ac_d[i] = ac_q[i];
      ir_d   = ld_ir ? data_in : ir_q;
      pc_d   = pc_q;
      in_d   = in_q;
      of_d   = of_q;
      sr_d   = sr_q;
      dout_d = dout_q;

      if (!ac_lock) begin
         if (zero_ac) begin
            ac_d[ac_sel] = '0;
         end else if (ld_ac) begin
            case (ac_src_e'(ac_src))
               ACS_IMM: ac_d[ac_sel] = imm;
               ACS_DIN: ac_d[ac_sel] = data_in;
               ACS_ALU: if (op != ALU_MUL) ac_d[ac_sel] = alu_res;
               default: ;
            endcase
         end
      end
      if (mul_done) ac_d[mul_ac_q] = mul_prod[DW-1:0];

      if (ld_pc) begin
         case (pc_src_e'(pc_src))
            PCS_INC: pc_d = pc_inc;
            PCS_DIN: pc_d = data_in;
            default: pc_d = imm;
         endcase
      end
      if (ld_in) in_d = in_src ? data_in : data_in + DW'(1);
      if (ld_of) of_d = of_src ? imm[OFW-1:0] : pc_q[DW-1 -: OFW];
      for (int i = 0; i < 4; i++) begin
         if (ld_sr[i]) sr_d[i] = sr_src ? ir_q[i] : flags[i];
      end

      if (wr_en) begin
         case (out_sel_e'(out_sel))
            OUT_IN:     dout_d = in_q;
            OUT_PC_INC: dout_d = pc_inc;
            OUT_AC:     dout_d = opnd_a;
            default:    dout_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NAC; i++) ac_q[i] <= '0;
         ir_q     <= '0;
         pc_q     <= '0;
         in_q     <= '0;
         of_q     <= '0;
         sr_q     <= '0;
         dout_q   <= '0;
         oe_q     <= 1'b0;
         mul_ac_q <= '0;
      end else begin
         for (int i = 0; i < NAC; i++) ac_q[i] <= ac_d[i];
         ir_q     <= ir_d;
         pc_q     <= pc_d;
         in_q     <= in_d;
         of_q     <= of_d;
         sr_q     <= sr_d;
         dout_q   <= dout_d;
         oe_q     <= wr_en;
         mul_ac_q <= mul_ac_d;
      end
   end

   always_comb begin
      case (adr_sel_e'(adr_sel))
         ADR_IN:  addr = in_q;
         ADR_IMM: addr = imm;
         default: addr = pc_q;
      endcase
   end

   assign data_out = dout_q;
   assign data_oe  = oe_q;
   assign busy     = mul_busy;
   assign done     = mul_done;
   assign ir_out   = ir_q;
   assign sr_out   = sr_q;
   assign skip     = |(ir_q[7:4] & ~(sr_q ^ ir_q[3:0]));

endmodule

// File: tb/tb_acc_datapath_mc.sv
module tb_acc_datapath_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data_in, data_out, addr, ir_out;
   logic        data_oe, wr_en, ld_ac, zero_ac, start, busy, done;
   logic [1:0]  out_sel, adr_sel, ac_sel, ac_src, opnd_sel, imm_mode, pc_src;
   logic [2:0]  alu_op;
   logic        ld_ir, ld_of, of_src, ld_pc, pc_inc2, ld_in, in_src, sr_src, skip;
   logic [3:0]  ld_sr, sr_out;

   int n_pass  = 0;
   int n_total = 0;

   logic [15:0] m_ac [4];

   acc_datapath_mc #(.DW(16), .NAC(4), .OFW(4)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
      .wr_en(wr_en), .out_sel(out_sel), .adr_sel(adr_sel), .addr(addr), .ac_sel(ac_sel),
      .ac_src(ac_src), .ld_ac(ld_ac), .zero_ac(zero_ac), .alu_op(alu_op), .opnd_sel(opnd_sel),
      .start(start), .busy(busy), .done(done), .imm_mode(imm_mode), .ld_ir(ld_ir),
      .ld_of(ld_of), .of_src(of_src), .ld_pc(ld_pc), .pc_src(pc_src), .pc_inc2(pc_inc2),
      .ld_in(ld_in), .in_src(in_src), .ld_sr(ld_sr), .sr_src(sr_src), .ir_out(ir_out),
      .sr_out(sr_out), .skip(skip)
   );

   always #5 clk = ~clk;

   task automatic idle;
      data_in = '0; wr_en = 0; out_sel = 0; adr_sel = 0; ac_sel = 0; ac_src = 0;
      ld_ac = 0; zero_ac = 0; alu_op = 0; opnd_sel = 0; start = 0; imm_mode = 0;
      ld_ir = 0; ld_of = 0; of_src = 0; ld_pc = 0; pc_src = 0; pc_inc2 = 0;
      ld_in = 0; in_src = 0; ld_sr = 0; sr_src = 0;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_ac(input int k, input logic [15:0] val);
      idle; ac_sel = 2'(k); ac_src = 1; ld_ac = 1; data_in = val;
      tick; idle;
      m_ac[k] = val;
   endtask

   task automatic read_ac(input int k, output logic [15:0] v);
      idle; ac_sel = 2'(k); out_sel = 2; wr_en = 1;
      tick; v = data_out; idle;
   endtask

   task automatic load_ir(input logic [15:0] val);
      idle; ld_ir = 1; data_in = val; tick; idle;
   endtask

   // Reference ALU from the arithmetic definition of each operation.
   function automatic void alu_ref(input int op, input int a, input int b,
                                   output int r, output logic [3:0] f);
      int sa, sb, s;
      logic c, v;
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (b >= 32768) ? b - 65536 : b;
      c = 0; v = 0; r = 0;
      case (op)
         0: begin r = (a + b) % 65536; c = (a + b) >= 65536;
                  s = sa + sb; v = (s > 32767) || (s < -32768); end
         1: begin r = (a - b + 65536) % 65536; c = (a < b);
                  s = sa - sb; v = (s > 32767) || (s < -32768); end
         2: r = a & b;
         3: r = 65535 - a;
         4: begin r = (a * 2) % 65536; c = (a >= 32768); end
         5: begin r = a / 2; c = (a % 2) == 1; end
         default: begin r = a / 2 + ((a >= 32768) ? 32768 : 0); c = (a % 2) == 1; end
      endcase
      f = {r == 0, r >= 32768, c, v};
   endfunction

   // Runs one multiply on AC[k]; probes an other-AC write, a locked-AC write,
   // an ignored restart and a same-AC load in the done cycle.
   task automatic do_mul(input int k, input logic [1:0] osel, input logic [15:0] din,
                         output int done_at, output int nbusy);
      int other;
      logic [15:0] oval;
      other = (k + 1) % 4;
      oval  = 16'($urandom_range(65535));
      idle; ac_sel = 2'(k); alu_op = 7; opnd_sel = osel; data_in = din; start = 1;
      tick;
      done_at = -1; nbusy = 0;
      for (int c = 1; c <= 20; c++) begin
         idle;
         if (busy) nbusy++;
         if (c == 3) begin ac_sel = 2'(other); ac_src = 1; ld_ac = 1; data_in = oval; end
         if (c == 4) begin ac_sel = 2'(k); ac_src = 1; ld_ac = 1; data_in = 16'hDEAD; end
         if (c == 5) begin ac_sel = 2'(k); alu_op = 7; opnd_sel = 1; data_in = 16'hFFFF; start = 1; end
         if (done) begin
            if (done_at < 0) done_at = c;
            ac_sel = 2'(k); ac_src = 1; ld_ac = 1; data_in = 16'h5555;
            ld_sr = 4'hF; sr_src = 0;
         end
         tick;
      end
      idle;
      m_ac[other] = oval;
   endtask

   task automatic check_mul(input string nm, input int k, input logic [15:0] a,
                            input logic [15:0] b);
      int done_at, nbusy, other;
      longint p;
      logic [15:0] lo, v;
      logic [3:0] f;
      other = (k + 1) % 4;
      p  = longint'(a) * longint'(b);
      lo = 16'(p % 65536);
      f  = {lo == 0, lo >= 16'h8000, (p / 65536) != 0, (p / 65536) != 0};
      do_mul(k, 2'd0, 16'h0, done_at, nbusy);
      m_ac[k] = lo;
      n_total++;
      if (done_at !== 16 || nbusy !== 16)
         $display("FAIL %s_handshake: done_at=%0d busy_cycles=%0d, need 16/16", nm, done_at, nbusy);
      else n_pass++;
      n_total++;
      if (sr_out !== f) $display("FAIL %s_flags: got %b need %b", nm, sr_out, f);
      else n_pass++;
      read_ac(k, v);
      n_total++;
      if (v !== lo) $display("FAIL %s_result: got %h need %h", nm, v, lo);
      else n_pass++;
      read_ac(other, v);
      n_total++;
      if (v !== m_ac[other]) $display("FAIL %s_other_ac: got %h need %h", nm, v, m_ac[other]);
      else n_pass++;
   endtask

   task automatic test_reset;
      logic [15:0] v;
      bit saw_done;
      idle; rst = 1; tick; tick; rst = 0;
      n_total++;
      if (addr !== 0 || ir_out !== 0 || sr_out !== 0 || busy !== 0 || done !== 0 ||
          data_oe !== 0 || data_out !== 0)
         $display("FAIL reset_state: addr=%h ir=%h sr=%b busy=%b done=%b oe=%b dout=%h, need all 0",
                  addr, ir_out, sr_out, busy, done, data_oe, data_out);
      else n_pass++;
      for (int i = 0; i < 4; i++) m_ac[i] = 0;

      load_ac(0, 16'h0003);
      idle; ac_sel = 0; alu_op = 7; opnd_sel = 2; start = 1; tick; idle;
      saw_done = 0;
      for (int c = 1; c <= 4; c++) begin
         if (done) saw_done = 1;
         tick;
      end
      rst = 1; tick; rst = 0;
      n_total++;
      if (busy !== 0) $display("FAIL reset_mid_mul_busy: got %b need 0", busy);
      else n_pass++;
      for (int c = 0; c < 20; c++) begin
         if (done) saw_done = 1;
         tick;
      end
      n_total++;
      if (saw_done) $display("FAIL reset_mid_mul_done: got done pulse, need none");
      else n_pass++;
      m_ac[0] = 0;
      read_ac(0, v);
      n_total++;
      if (v !== 0) $display("FAIL reset_mid_mul_ac: got %h need 0000", v);
      else n_pass++;
   endtask

   task automatic test_add_overflow;
      logic [15:0] v;
      load_ac(0, 16'h7FFF);
      load_ir(16'h0001);
      idle; ac_sel = 0; alu_op = 0; opnd_sel = 0; ac_src = 2; ld_ac = 1; ld_sr = 4'hF;
      tick; idle;
      n_total++;
      if (sr_out !== 4'b0101) $display("FAIL add_ovf_flags: got %b need 0101", sr_out);
      else n_pass++;
      read_ac(0, v);
      n_total++;
      if (v !== 16'h8000) $display("FAIL add_ovf_result: got %h need 8000", v);
      else n_pass++;
      m_ac[0] = 16'h8000;
   endtask

   task automatic test_alu_random;
      logic [15:0] a, b, v;
      logic [3:0] f;
      int op, k, r;
      for (int i = 0; i < 30; i++) begin
         k  = $urandom_range(3);
         op = (i < 7) ? i : $urandom_range(6);
         a  = 16'($urandom_range(65535));
         b  = 16'($urandom_range(65535));
         if (i == 7) begin a = 16'h0000; b = 16'h0001; op = 1; end
         if (i == 8) begin a = 16'hFFFF; b = 16'h0001; op = 0; end
         if (i == 9) begin a = 16'h8000; b = 16'h0001; op = 1; end
         load_ac(k, a);
         idle; ac_sel = 2'(k); alu_op = 3'(op); opnd_sel = 1; data_in = b;
         ac_src = 2; ld_ac = 1; ld_sr = 4'hF;
         tick; idle;
         alu_ref(op, int'(a), int'(b), r, f);
         m_ac[k] = 16'(r);
         n_total++;
         if (sr_out !== f) $display("FAIL alu_flags op%0d a=%h b=%h: got %b need %b", op, a, b, sr_out, f);
         else n_pass++;
         read_ac(k, v);
         n_total++;
         if (v !== 16'(r)) $display("FAIL alu_result op%0d a=%h b=%h: got %h need %h", op, a, b, v, 16'(r));
         else n_pass++;
      end
      a = 16'($urandom_range(65535));
      load_ac(1, a);
      idle; ac_sel = 1; alu_op = 7; opnd_sel = 1; data_in = 16'h1234; ac_src = 2; ld_ac = 1;
      tick; idle;
      read_ac(1, v);
      n_total++;
      if (v !== a || busy !== 0) $display("FAIL alu_mul_ldac_hold: got %h busy=%b need %h busy=0", v, busy, a);
      else n_pass++;
   endtask

   task automatic test_mul;
      int done_at, nbusy;
      logic [15:0] v;
      load_ac(2, 16'h0123);
      do_mul(2, 2'd1, 16'h0010, done_at, nbusy);
      m_ac[2] = 16'h1230;
      n_total++;
      if (done_at !== 16 || nbusy !== 16)
         $display("FAIL mul_handshake: done_at=%0d busy_cycles=%0d, need 16/16", done_at, nbusy);
      else n_pass++;
      read_ac(2, v);
      n_total++;
      if (v !== 16'h1230) $display("FAIL mul_result: got %h need 1230", v);
      else n_pass++;
      read_ac(3, v);
      n_total++;
      if (v !== m_ac[3]) $display("FAIL mul_other_ac: got %h need %h", v, m_ac[3]);
      else n_pass++;
      n_total++;
      if (sr_out !== 4'b0000) $display("FAIL mul_flags: got %b need 0000", sr_out);
      else n_pass++;
   endtask

   task automatic test_mul_overflow;
      int done_at, nbusy;
      logic [15:0] v;
      load_ac(1, 16'h8000);
      do_mul(1, 2'd2, 16'h0, done_at, nbusy);
      read_ac(1, v);
      n_total++;
      if (v !== 16'h8000 || sr_out !== 4'b0100)
         $display("FAIL mul_by_one: got %h/%b need 8000/0100", v, sr_out);
      else n_pass++;
      load_ir(16'h0002);
      do_mul(1, 2'd0, 16'h0, done_at, nbusy);
      m_ac[1] = 0;
      n_total++;
      if (done_at !== 16 || nbusy !== 16)
         $display("FAIL mul_ovf_restart_ignored: done_at=%0d busy_cycles=%0d, need 16/16", done_at, nbusy);
      else n_pass++;
      read_ac(1, v);
      n_total++;
      if (v !== 16'h0000 || sr_out !== 4'b1011)
         $display("FAIL mul_ovf: got %h/%b need 0000/1011", v, sr_out);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         logic [15:0] a, b;
         a = 16'($urandom_range(65535));
         b = 16'($urandom_range(65535));
         load_ir(b);
         idle; imm_mode = 0;
         load_ac(i, a);
         // Operand comes from the zero-extended 12-bit immediate.
         check_mul("mul_rand", i, a, {4'h0, b[11:0]});
      end
   endtask

   task automatic test_pc;
      logic [15:0] v, ir, pcv, e;
      idle; ld_pc = 1; pc_src = 1; data_in = 16'hFFFF; tick;
      idle; ld_pc = 1; pc_src = 0; pc_inc2 = 1; tick;
      idle; adr_sel = 2; #1;
      n_total++;
      if (addr !== 16'h0001) $display("FAIL pc_wrap_inc2: got %h need 0001", addr);
      else n_pass++;
      adr_sel = 3; #1;
      n_total++;
      if (addr !== 16'h0001) $display("FAIL pc_adr_sel3: got %h need 0001", addr);
      else n_pass++;
      idle; out_sel = 1; wr_en = 1; tick; idle;
      n_total++;
      if (data_out !== 16'h0002 || data_oe !== 1)
         $display("FAIL pc_inc_out: got %h oe=%b need 0002 oe=1", data_out, data_oe);
      else n_pass++;
      tick;
      n_total++;
      if (data_oe !== 0) $display("FAIL data_oe_drop: got %b need 0", data_oe);
      else n_pass++;

      idle; ld_in = 1; in_src = 0; data_in = 16'hFFFF; tick; idle; #1;
      n_total++;
      if (addr !== 16'h0000) $display("FAIL in_wrap: got %h need 0000", addr);
      else n_pass++;
      v = 16'($urandom_range(65535));
      idle; ld_in = 1; in_src = 1; data_in = v; tick;
      idle; out_sel = 0; wr_en = 1; tick; idle;
      n_total++;
      if (addr !== v || data_out !== v) $display("FAIL in_load: got %h/%h need %h", addr, data_out, v);
      else n_pass++;

      for (int i = 0; i < 6; i++) begin
         int z12, s12, s4, pg;
         ir  = 16'($urandom_range(65535));
         pcv = 16'($urandom_range(65535));
         load_ir(ir);
         z12 = int'(ir) % 4096;
         s12 = (z12 >= 2048) ? z12 + 16'hF000 : z12;
         s4  = int'(ir) % 16;
         s4  = (s4 >= 8) ? s4 + 16'hFFF0 : s4;
         idle; ld_pc = 1; pc_src = 1; data_in = pcv; tick;
         idle; ld_of = 1; of_src = 0; tick;
         idle; imm_mode = 3; adr_sel = 1; #1;
         pg = (int'(pcv) / 4096) * 4096 + z12;
         n_total++;
         if (addr !== 16'(pg)) $display("FAIL imm_page_pc ir=%h pc=%h: got %h need %h", ir, pcv, addr, 16'(pg));
         else n_pass++;
         idle; ld_of = 1; of_src = 1; imm_mode = 0; tick;
         pg = (int'(ir) % 16) * 4096 + z12;
         for (int m = 0; m < 4; m++) begin
            e = (m == 0) ? 16'(z12) : (m == 1) ? 16'(s12) : (m == 2) ? 16'(s4) : 16'(pg);
            idle; imm_mode = 2'(m); adr_sel = 1; #1;
            n_total++;
            if (addr !== e) $display("FAIL imm_mode%0d ir=%h: got %h need %h", m, ir, addr, e);
            else n_pass++;
         end
         idle; ld_pc = 1; pc_src = 2; imm_mode = 1; tick;
         idle; adr_sel = 2; #1;
         n_total++;
         if (addr !== 16'(s12)) $display("FAIL pc_load_imm ir=%h: got %h need %h", ir, addr, 16'(s12));
         else n_pass++;
      end
   endtask

   task automatic test_skip;
      logic [15:0] ir;
      logic [3:0] s;
      bit exp;
      load_ir(16'h000A);
      idle; ld_sr = 4'hF; sr_src = 1; tick; idle;
      n_total++;
      if (sr_out !== 4'b1010) $display("FAIL sr_from_ir: got %b need 1010", sr_out);
      else n_pass++;
      load_ir(16'h008A); #1;
      n_total++;
      if (skip !== 1) $display("FAIL skip_8a: got %b need 1", skip);
      else n_pass++;
      load_ir(16'h0045); #1;
      n_total++;
      if (skip !== 0) $display("FAIL skip_45: got %b need 0", skip);
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
         s  = 4'($urandom_range(15));
         ir = 16'($urandom_range(65535));
         load_ir({12'h0, s});
         idle; ld_sr = 4'hF; sr_src = 1; tick;
         load_ir(ir); #1;
         exp = 0;
         for (int bnum = 0; bnum < 4; bnum++)
            if (ir[bnum + 4] && (s[bnum] == ir[bnum])) exp = 1;
         n_total++;
         if (skip !== exp) $display("FAIL skip_rand sr=%b ir=%h: got %b need %b", s, ir, skip, exp);
         else n_pass++;
      end
   endtask

   initial begin
      idle;
      rst = 1;
      test_reset;
      test_add_overflow;
      test_alu_random;
      test_mul;
      test_mul_overflow;
      test_pc;
      test_skip;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
